// File: rtl/key_expansion_ctrl.sv
// key_expansion_ctrl: AES-128 key expansion sequencer.
// Loads a 128-bit cipher key and produces round keys 1..NUM_ROUNDS, one per
// cycle. All NUM_ROUNDS+1 keys go into an internal key store. A registered
// read port serves the round keys to the cipher datapath. SubWord is done by an
// external combinational S-box through Sbox_in/Sbox_out.
// Optional feature macro: KEY_EXP_EARLY_READ_EN. When it is defined, the key
// store may be read during expansion for entries that are already written.
module key_expansion_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [127:0]          Key_in,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Key_ready,
  output logic [31:0]           Sbox_in,
  input  logic [31:0]           Sbox_out,
  input  logic                  Rk_rd,
  input  logic [ADDR_WIDTH-1:0] Rk_addr,
  output logic [127:0]          Rk_data,
  output logic                  Rk_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROUND = ADDR_WIDTH'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXPAND,
    ST_DONE
  } state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] round_reg, round_next;
  logic [7:0]            rcon_reg, rcon_next;
  logic                  ready_reg, ready_next;
  logic [31:0]           w_reg [0:3];
  logic [31:0]           w_next [0:3];

  logic [31:0]           key_word [0:3];
  logic [31:0]           exp_word [0:3];
  logic [127:0]          work_key;
  logic [127:0]          exp_key;
  logic [31:0]           temp_word;
  logic [7:0]            rcon_xtime;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [127:0]          wr_data;

  logic [127:0]          store_mem [0:NUM_ROUNDS];

  logic                  rd_permit;
  logic                  rd_hit;
  logic                  rk_valid_reg;
  logic [127:0]          rk_data_reg;

  // Word 0 is the most significant word of a 128-bit key, both on input and in the store.
  for (genvar gi = 0; gi < 4; gi++) begin : g_words
    assign key_word[gi]                = Key_in[127-32*gi -: 32];
    assign work_key[127-32*gi -: 32]   = w_reg[gi];
    assign exp_key[127-32*gi -: 32]    = exp_word[gi];
  end

  // RotWord of the working w3 always feeds the shared S-box.
  assign Sbox_in    = {w_reg[3][23:0], w_reg[3][31:24]};
  assign temp_word  = Sbox_out ^ {rcon_reg, 24'h0};
  assign rcon_xtime = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1B : 8'h00);

  // Build the next round's words from the running XOR chain.
  always_comb begin
    exp_word[0] = w_reg[0] ^ temp_word;
    for (int i = 1; i < 4; i++) begin
      exp_word[i] = w_reg[i] ^ exp_word[i-1];
    end
  end

  // Next-state logic and store write port.
  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    rcon_next  = rcon_reg;
    ready_next = ready_reg;
    w_next     = w_reg;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = work_key;
    case (state_reg)
      ST_IDLE: begin
        if (Start) begin
          w_next     = key_word;
          ready_next = 1'b0;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        wr_en      = 1'b1;
        wr_addr    = '0;
        wr_data    = work_key;
        round_next = ADDR_WIDTH'(1);
        rcon_next  = 8'h01;
        state_next = ST_EXPAND;
      end
      ST_EXPAND: begin
        wr_en     = 1'b1;
        wr_addr   = round_reg;
        wr_data   = exp_key;
        w_next    = exp_word;
        rcon_next = rcon_xtime;
        if (round_reg == LAST_ROUND) begin
          state_next = ST_DONE;
        end else begin
          round_next = round_reg + ADDR_WIDTH'(1);
        end
      end
      ST_DONE: begin
        ready_next = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Control and working-key registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= ST_IDLE;
      round_reg <= '0;
      rcon_reg  <= 8'h01;
      ready_reg <= 1'b0;
      w_reg     <= '{default: '0};
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
      rcon_reg  <= rcon_next;
      ready_reg <= ready_next;
      w_reg     <= w_next;
    end
  end

  // The key store is not reset, so it can map onto block RAM.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      store_mem[wr_addr] <= wr_data;
    end
  end

`ifdef KEY_EXP_EARLY_READ_EN
  // Entries below the round now being written are already final.
  assign rd_permit = ready_reg || (state_reg == ST_DONE) ||
                     ((state_reg == ST_EXPAND) && (Rk_addr < round_reg));
`else
  assign rd_permit = ready_reg;
`endif

  assign rd_hit = Rk_rd && (Rk_addr <= LAST_ROUND) && rd_permit;

  // Registered read port. A miss clears the data, and an idle cycle holds it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rk_valid_reg <= 1'b0;
      rk_data_reg  <= '0;
    end else begin
      rk_valid_reg <= rd_hit;
      if (rd_hit) begin
        rk_data_reg <= store_mem[Rk_addr];
      end else if (Rk_rd) begin
        rk_data_reg <= '0;
      end
    end
  end

  assign Busy      = (state_reg != ST_IDLE);
  assign Done      = (state_reg == ST_DONE);
  assign Key_ready = ready_reg;
  assign Rk_valid  = rk_valid_reg;
  assign Rk_data   = rk_data_reg;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// tb_key_expansion_ctrl: self-checking bench for key_expansion_ctrl.
// The reference model is the standard FIPS-197 word-array key schedule, driven
// by an S-box that is derived from GF(2^8) inversion. Reads are checked against
// the cycle-level permission rules. The KEY_EXP_EARLY_READ_EN macro selects
// which permission rules apply.
module tb_key_expansion_ctrl;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         Clk;
  logic         Rst;
  logic         Start;
  logic [127:0] Key_in;
  logic         Busy;
  logic         Done;
  logic         Key_ready;
  logic [31:0]  Sbox_in;
  logic [31:0]  Sbox_out;
  logic         Rk_rd;
  logic [3:0]   Rk_addr;
  logic [127:0] Rk_data;
  logic         Rk_valid;

  int tests = 0;
  int fails = 0;

  logic [7:0]   sbox_tab [0:255];
  logic [7:0]   rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [127:0] ref_keys [0:10];
  logic [31:0]  ref_w [0:43];
  logic [127:0] exp_data;
  bit           ready_model;

  key_expansion_ctrl #(.NUM_ROUNDS(10), .ADDR_WIDTH(4)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Key_in(Key_in),
    .Busy(Busy), .Done(Done), .Key_ready(Key_ready),
    .Sbox_in(Sbox_in), .Sbox_out(Sbox_out),
    .Rk_rd(Rk_rd), .Rk_addr(Rk_addr), .Rk_data(Rk_data), .Rk_valid(Rk_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // External S-box model: four byte lookups.
  assign Sbox_out = {sbox_tab[Sbox_in[31:24]], sbox_tab[Sbox_in[23:16]],
                     sbox_tab[Sbox_in[15:8]], sbox_tab[Sbox_in[7:0]]};

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic compute_ref(input logic [127:0] key);
    logic [31:0] t;
    for (int i = 0; i < 4; i++) ref_w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = ref_w[i-1];
      if (i % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/4-1], 24'h0};
      ref_w[i] = ref_w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      ref_keys[r] = {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
  endtask

  // May a read issued during cycle q of an expansion hit? q=1 is the load cycle.
  function automatic bit permitted(input int q, input int addr);
    if (addr > 10) return 1'b0;
    if (q >= 13) return 1'b1;
`ifdef KEY_EXP_EARLY_READ_EN
    if (q == 12) return 1'b1;
    if (q >= 2 && q <= 11) return (addr < q - 1);
`endif
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_read(input bit rd, input int addr, input bit perm, input string tag);
    if (rd) exp_data = perm ? ref_keys[addr] : 128'h0;
    check_bit({tag, "_valid"}, Rk_valid, rd && perm);
    check({tag, "_data"}, Rk_data, exp_data);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_busy"}, Busy, 1'b0);
    check_bit({tag, "_done"}, Done, 1'b0);
    check_bit({tag, "_key_ready"}, Key_ready, 1'b0);
    check_bit({tag, "_rk_valid"}, Rk_valid, 1'b0);
    check({tag, "_rk_data"}, Rk_data, 128'h0);
  endtask

  // One expansion, observed cycle by cycle. mode 0 issues random reads.
  // Modes 1 and 2 read addr 2 or addr 4 during round 4. hold keeps Start high
  // through the first DONE, which starts a second expansion.
  task automatic expand(input logic [127:0] key, input int mode, input bit hold);
    int last;
    int q;
    int prev_q;
    bit rd_q;
    int addr_q;
    compute_ref(key);
    Key_in = key; Start = 1'b1; Rk_rd = 1'b0;
    last = hold ? 26 : 13;
    rd_q = 1'b0; addr_q = 0; prev_q = 0;
    for (int p = 1; p <= last; p++) begin
      tick();
      q = (p > 13) ? p - 13 : p;
      if (!hold || p >= 14) Start = 1'b0;
      check_bit($sformatf("busy_c%0d", p), Busy, q <= 12);
      check_bit($sformatf("done_c%0d", p), Done, q == 12);
      check_bit($sformatf("key_ready_c%0d", p), Key_ready, q >= 13);
      check_read(rd_q, addr_q, permitted(prev_q, addr_q), $sformatf("rd_c%0d_a%0d", p, addr_q));
      if (mode == 1 && q == 6) begin
`ifdef KEY_EXP_EARLY_READ_EN
        check("early_rk2", Rk_data, FIPS_RK2);
`else
        check_bit("early_rk2_blocked", Rk_valid, 1'b0);
`endif
      end
      if (mode == 2 && q == 6) check_bit("early_rk4_blocked", Rk_valid, 1'b0);
      prev_q = q;
      if (p == last) begin
        rd_q = 1'b0;
      end else if (mode == 0) begin
        rd_q = 1'($urandom_range(0, 1));
        addr_q = int'($urandom_range(0, 15));
      end else begin
        rd_q = (q == 5);
        addr_q = (mode == 1) ? 2 : 4;
      end
      Rk_rd = rd_q; Rk_addr = 4'(addr_q);
    end
    Rk_rd = 1'b0;
    ready_model = 1'b1;
  endtask

  task automatic read_idle(input int addr);
    Rk_rd = 1'b1; Rk_addr = 4'(addr);
    tick();
    Rk_rd = 1'b0;
    check_read(1'b1, addr, ready_model && addr <= 10, $sformatf("idle_rd_a%0d", addr));
  endtask

  initial begin
    logic [127:0] rkey;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    Rst = 1'b1; Start = 1'b0; Key_in = '0; Rk_rd = 1'b0; Rk_addr = '0;
    exp_data = '0; ready_model = 1'b0;

    // Reset state, then a read before any key exists.
    repeat (2) tick();
    check_reset_outputs("reset");
    Rst = 1'b0;
    read_idle(0);
    // Asynchronous reset pulse while idle.
    tick();
    #2 Rst = 1'b1;
    #1 check_reset_outputs("idle_rst");
    tick();
    Rst = 1'b0;

    // FIPS-197 key with random reads throughout, then the known round keys.
    expand(FIPS_KEY, 0, 1'b0);
    read_idle(0);
    check("fips_rk0", Rk_data, FIPS_KEY);
    read_idle(1);
    check("fips_rk1", Rk_data, FIPS_RK1);
    read_idle(10);
    check("fips_rk10", Rk_data, FIPS_RK10);
    tick();
    check_bit("hold_valid", Rk_valid, 1'b0);
    check("hold_data", Rk_data, FIPS_RK10);
    read_idle(11);
    read_idle(15);

    // Start held high: one full expansion, then an immediate second one.
    expand(FIPS_KEY, 0, 1'b1);
    read_idle(2);

    // Reset during EXPAND round 5, then re-expand the same key.
    rkey = {$urandom, $urandom, $urandom, $urandom};
    Key_in = rkey; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (5) tick();
    check_bit("busy_before_rst", Busy, 1'b1);
    #1 Rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    exp_data = '0; ready_model = 1'b0;
    tick(); tick();
    Rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      check_bit("post_rst_done", Done, 1'b0);
      check_bit("post_rst_busy", Busy, 1'b0);
      check_bit("post_rst_key_ready", Key_ready, 1'b0);
    end
    read_idle(0);
    expand(rkey, 0, 1'b0);
    for (int a = 0; a <= 10; a++) read_idle(a);

    // Reads during round 4 of the expansion.
    expand(FIPS_KEY, 1, 1'b0);
    expand(FIPS_KEY, 2, 1'b0);

    // Random keys with random reads afterwards.
    for (int k = 0; k < 3; k++) begin
      expand({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0);
      for (int j = 0; j < 5; j++) read_idle(int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_expansion_ctrl.md
Name: key_expansion_ctrl

Overview:
Sequencer for AES-128 key expansion. Accepts a 128-bit cipher key on Start, generates round keys 1..NUM_ROUNDS one per cycle, and stores all NUM_ROUNDS+1 keys in an internal key store. A registered read port serves round keys to the cipher round datapath. SubWord is computed by a shared external combinational S-box unit driven through the Sbox_in/Sbox_out ports.

Parameters:
NUM_ROUNDS, 10, number of round keys after the initial key; the store holds NUM_ROUNDS+1 entries of 128 bits.
ADDR_WIDTH, 4, width of the round-key read address.

Ports:
Clk  input  1  clock; all state updates on the rising edge.
Rst  input  1  reset, asynchronous, active-high.
Start  input  1  request expansion of Key_in; sampled only in IDLE.
Key_in  input  128  cipher key; word w0 = [127:96]; captured in the cycle Start is accepted.
Busy  output  1  high from LOAD through DONE inclusive.
Done  output  1  one-cycle pulse in the DONE state.
Key_ready  output  1  key store complete and valid.
Sbox_in  output  32  RotWord(w3) of the current working key: {w3[23:0], w3[31:24]}.
Sbox_out  input  32  SubWord(Sbox_in), combinational, returned in the same cycle.
Rk_rd  input  1  round-key read strobe.
Rk_addr  input  ADDR_WIDTH  round index to read, 0..NUM_ROUNDS.
Rk_data  output  128  registered read data.
Rk_valid  output  1  registered qualifier for Rk_data.

Behaviour:
- Reset values (asynchronous, while Rst=1): state=IDLE; Busy=0, Done=0, Key_ready=0, Rk_valid=0, Rk_data=0; round counter=0; rcon=8'h01; working words=0. The key store contents are not reset.
- FSM states: IDLE, LOAD, EXPAND, DONE.
  - IDLE: if Start=1, capture Key_in into working words w0..w3, clear Key_ready, and go to LOAD.
  - LOAD: write the working key to store[0]; set round=1 and rcon=8'h01; go to EXPAND.
  - EXPAND: one round per cycle:
    - temp = Sbox_out ^ {rcon, 24'h0}
    - w0' = w0^temp, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'
    - write {w0',w1',w2',w3'} to store[round]; update the working words
    - rcon <= xtime(rcon): shift left by 1; if the old bit 7 was 1, XOR with 8'h1B
    - if round==NUM_ROUNDS go to DONE, else round <= round+1
  - DONE: Done=1 for this cycle only; Key_ready <= 1; go to IDLE.
- Rcon sequence across rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- Timing: Start sampled at edge N; LOAD during cycle N+1; EXPAND during cycles N+2..N+11; DONE during cycle N+12.
  - Busy is 1 for exactly 12 cycles.
  - Key_ready reads 1 from the cycle after DONE.
- Start while Busy=1 is ignored: no restart, no queuing.
- Start in IDLE while Key_ready=1 clears Key_ready in the next cycle and starts re-expansion.
- Sbox_in is driven from the working w3 in every state; it is don't-care outside EXPAND.
- Read port, 1-cycle latency: Rk_rd sampled at edge N gives Rk_data/Rk_valid valid after edge N+1.
  - Hit (Rk_rd=1, Rk_addr<=NUM_ROUNDS, read permitted): Rk_valid=1, Rk_data=store[Rk_addr].
  - Miss (out-of-range address, or read not permitted): Rk_valid=1 is never produced; Rk_valid=0 and Rk_data=0.
  - Rk_rd=0: Rk_valid=0 next cycle; Rk_data holds its last value.
- Read permission without the optional feature: Key_ready=1.
- Reset asserted mid-expansion: all outputs immediately take reset values and Key_ready=0. After reset release, the block requires a new Start.

Optional Feature:
KEY_EXP_EARLY_READ_EN
- Defined: reads are also permitted while Busy=1 for any Rk_addr already written.
  - In EXPAND at round r: addresses 0..r-1 are permitted.
  - In DONE: all addresses are permitted.
  - A read of the entry being written in the same cycle is not permitted.
  - Lets the cipher start round 0 before expansion completes.
- Not defined: reads require Key_ready=1; any read during Busy returns Rk_valid=0.

Test Plan:
- Rst=1 pulse mid-idle -> all outputs 0, Busy=0, Key_ready=0; Rk_rd with Rk_addr=0 -> Rk_valid=0.
- Key_in=2b7e151628aed2a6abf7158809cf4f3c with Start, bench S-box model -> Done pulses 12 cycles after Start; then:
  - read addr 0 -> 2b7e151628aed2a6abf7158809cf4f3c
  - read addr 1 -> a0fafe1788542cb123a339392a6c7605
  - read addr 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6
  - Rk_valid=1 for each read.
- Start held high for 20 cycles -> exactly one expansion, one Done pulse, Busy high exactly 12 cycles; then Start still high -> a second expansion begins and Key_ready drops.
- After a completed expansion, Rk_rd with Rk_addr=11 and Rk_addr=15 -> Rk_valid=0, Rk_data=0.
- Rst asserted during EXPAND round 5 -> Busy=0 and Key_ready=0 immediately; no Done pulse; a fresh Start with the same key -> identical round keys.
- During EXPAND round 4, read addr 2 then addr 4 -> with KEY_EXP_EARLY_READ_EN: valid with the FIPS-197 round-2 key, then Rk_valid=0 for addr 4; without the macro: Rk_valid=0 for both.
